// File: rtl/seq_sub64.sv
// Multi-cycle subtractor: diff = a - b via a + ~b + 1, CHUNK bits per cycle, LSB first.
// Produces ZF/SF/OF condition codes plus an unsigned borrow, with valid/ready on both sides.
module seq_sub64 #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             borrow
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, nb_sh, acc, acc_nxt;
    logic             carry;
    logic [CW-1:0]    count;
    logic [CHUNK:0]   sum;
    logic             last;
    logic             c_msb_in;

    assign in_ready = (state == IDLE);

    always_comb begin
        sum      = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, nb_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
        // New chunk enters from the MSB side; after NCHUNK steps acc holds the full result.
        acc_nxt  = (acc >> CHUNK) | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        last     = (count == CW'(NCHUNK - 1));
        // Carry into the top bit recovered from its sum bit and operand bits.
        c_msb_in = a_sh[CHUNK-1] ^ nb_sh[CHUNK-1] ^ sum[CHUNK-1];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = BUSY;
            BUSY:    if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            nb_sh     <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            count     <= '0;
            diff      <= '0;
            zf        <= 1'b0;
            sf        <= 1'b0;
            of        <= 1'b0;
            borrow    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        nb_sh <= ~b;
                        acc   <= '0;
                        carry <= 1'b1;
                        count <= '0;
                    end
                end
                BUSY: begin
                    a_sh  <= a_sh >> CHUNK;
                    nb_sh <= nb_sh >> CHUNK;
                    acc   <= acc_nxt;
                    carry <= sum[CHUNK];
                    count <= count + CW'(1);
                    if (last) begin
                        diff      <= acc_nxt;
                        zf        <= (acc_nxt == '0);
                        sf        <= acc_nxt[WIDTH-1];
                        of        <= c_msb_in ^ sum[CHUNK];
                        borrow    <= ~sum[CHUNK];
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_sub64.sv
// Directed bench for seq_sub64 (WIDTH=64, CHUNK=8): results, flags, latency,
// backpressure and asynchronous reset mid-operation.
module tb_seq_sub64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] diff;
    logic        zf, sf, of, borrow;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seq_sub64 #(.WIDTH(64), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .zf(zf), .sf(sf), .of(of), .borrow(borrow)
    );

    // Issues one operation from IDLE and waits (bounded) for out_valid.
    task automatic start_op(input logic [63:0] aa, input logic [63:0] bb,
                            output int lat, output bit rdy_low);
        @(negedge clk);
        a = aa; b = bb; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        rdy_low = 1'b1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (in_ready) rdy_low = 1'b0;
        end
    endtask

    task automatic accept_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_total++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_hs ready/valid=%b required 10", {in_ready, out_valid});
        else n_pass++;
        n_total++;
        if ({diff, zf, sf, of, borrow} !== 68'h0) $display("FAIL reset_out diff=%h flags=%b required 0", diff, {zf, sf, of, borrow});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat; bit rl;
        start_op(64'd5, 64'd3, lat, rl);
        n_total++;
        if (lat !== 8) $display("FAIL basic_latency got %0d required 8", lat); else n_pass++;
        n_total++;
        if (rl !== 1'b1) $display("FAIL basic_in_ready_low got %b required 1", rl); else n_pass++;
        n_total++;
        if (diff !== 64'd2) $display("FAIL basic_diff got %h required 2", diff); else n_pass++;
        n_total++;
        if ({zf, sf, of, borrow} !== 4'b0000) $display("FAIL basic_flags got %b required 0000", {zf, sf, of, borrow});
        else n_pass++;
        accept_result();
        n_total++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL basic_handshake got %b required 10", {in_ready, out_valid});
        else n_pass++;
    endtask

    task automatic test_overflow();
        int lat; bit rl;
        start_op(64'h8000000000000000, 64'd1, lat, rl);
        n_total++;
        if (diff !== 64'h7FFFFFFFFFFFFFFF) $display("FAIL min_minus_1_diff got %h required 7fffffffffffffff", diff);
        else n_pass++;
        n_total++;
        if ({zf, sf, of, borrow} !== 4'b0010) $display("FAIL min_minus_1_flags got %b required 0010", {zf, sf, of, borrow});
        else n_pass++;
        accept_result();
        start_op(64'h7FFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, lat, rl);
        n_total++;
        if (diff !== 64'h8000000000000000) $display("FAIL max_minus_m1_diff got %h required 8000000000000000", diff);
        else n_pass++;
        n_total++;
        if ({zf, sf, of, borrow} !== 4'b0111) $display("FAIL max_minus_m1_flags got %b required 0111", {zf, sf, of, borrow});
        else n_pass++;
        accept_result();
        start_op(64'd0, 64'h8000000000000000, lat, rl);
        n_total++;
        if ({diff, zf, sf, of, borrow} !== {64'h8000000000000000, 4'b0111})
            $display("FAIL zero_minus_min got %h/%b required 8000000000000000/0111", diff, {zf, sf, of, borrow});
        else n_pass++;
        accept_result();
    endtask

    task automatic test_zero_and_borrow();
        int lat; bit rl;
        start_op(64'd42, 64'd42, lat, rl);
        n_total++;
        if ({diff, zf, sf, of, borrow} !== {64'd0, 4'b1000})
            $display("FAIL equal_ops got %h/%b required 0/1000", diff, {zf, sf, of, borrow});
        else n_pass++;
        accept_result();
        start_op(64'd0, 64'd1, lat, rl);
        n_total++;
        if ({diff, zf, sf, of, borrow} !== {64'hFFFFFFFFFFFFFFFF, 4'b0101})
            $display("FAIL zero_minus_one got %h/%b required ffffffffffffffff/0101", diff, {zf, sf, of, borrow});
        else n_pass++;
        accept_result();
        start_op(64'h00000001_00000000, 64'h00000000_00000001, lat, rl);
        n_total++;
        if ({diff, zf, sf, of, borrow} !== {64'h00000000_FFFFFFFF, 4'b0000})
            $display("FAIL carry_chain got %h/%b required 00000000ffffffff/0000", diff, {zf, sf, of, borrow});
        else n_pass++;
        accept_result();
    endtask

    task automatic test_backpressure();
        int lat; bit rl; bit stable;
        start_op(64'd1000, 64'd1, lat, rl);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            a = 64'd77; b = 64'd7;
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || diff !== 64'd999 || {zf, sf, of, borrow} !== 4'b0000) stable = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_total++;
        if (stable !== 1'b1) $display("FAIL backpressure_hold got %b required 1 (diff=%h)", stable, diff); else n_pass++;
        accept_result();
        n_total++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL backpressure_release got %b required 10", {in_ready, out_valid});
        else n_pass++;
        start_op(64'd7, 64'd2, lat, rl);
        n_total++;
        if (diff !== 64'd5 || lat !== 8) $display("FAIL back_to_back got diff=%h lat=%0d required 5/8", diff, lat);
        else n_pass++;
        accept_result();
    endtask

    task automatic test_reset_mid_busy();
        int lat; bit rl;
        start_op(64'd0, 64'd1, lat, rl);
        accept_result();
        @(negedge clk);
        a = 64'd9; b = 64'd4; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({in_ready, out_valid, diff, zf, sf, of, borrow} !== {2'b10, 64'd0, 4'b0000})
            $display("FAIL reset_mid_busy got rdy/vld=%b diff=%h flags=%b required 10/0/0000",
                     {in_ready, out_valid}, diff, {zf, sf, of, borrow});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        start_op(64'd100, 64'd58, lat, rl);
        n_total++;
        if (diff !== 64'd42 || lat !== 8) $display("FAIL after_reset_op got diff=%h lat=%0d required 2a/8", diff, lat);
        else n_pass++;
        accept_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_zero_and_borrow();
        test_backpressure();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
